// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared definitions for the sequential ALU.
//
// Contents:
//   alu_op_t     opcode encoding seen on seq_alu.op (values 6-7 are illegal)
//   FLAG_*       bit positions of N, Z, C, V inside the 4-bit flags word
//   alu_state_t  control FSM states of seq_alu
//   pack_flags   builds a flags word from individual N/Z/C/V bits
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4,
        OP_MOV = 3'd5
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        DIV_RUN = 1'b1
    } alu_state_t;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_div.sv
// -----------------------------------------------------------------------------
// div_restoring -- iterative unsigned restoring divider, one quotient bit per
// clock, MSB first.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears all state, aborts a run
//   load       capture dividend/divisor and start WIDTH iterations
//   dividend   WIDTH-bit numerator
//   divisor    WIDTH-bit denominator (caller guarantees nonzero)
//   quotient   quotient as it stands after the current iteration
//   remainder  remainder as it stands after the current iteration
//   last       high during the final iteration; quotient/remainder then carry
//              the finished result, so the caller can register it on the same
//              edge that retires the last bit
// -----------------------------------------------------------------------------
module div_restoring #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // One extra bit above the remainder so the trial subtraction's sign is
    // visible even though the shifted partial remainder can reach 2*divisor-1.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        rem_d   = rem_q;
        quo_d   = quo_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {2'b00, dvs_q};
        if (!trial[WIDTH+1]) begin
            // Divisor fits: keep the difference and emit a 1 quotient bit.
            rem_d = trial[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign quotient  = quo_d;
    assign remainder = rem_d[WIDTH-1:0];
    assign last      = run_q && (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential execute-stage ALU with start/busy/done handshake.
//
// ADD, SUB, MUL, MOV, illegal opcodes and divide-by-zero complete one edge
// after start. DIV/MOD with a nonzero divisor run on div_restoring for WIDTH
// edges while busy stalls the pipeline.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (aborts a running divide)
//   start   request; only sampled while busy is low
//   op      opcode (alu_op_t encoding, 6-7 illegal)
//   a, b    operands, captured at the start edge (b is the MOV source)
//   busy    divider iterating; start is ignored
//   done    one-cycle pulse when result/flags have just been written
//   result  registered result, held until the next completion
//   flags   registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    import alu_pkg::*;

    alu_state_t       state_q;
    logic             is_mod_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             done_q;

    alu_op_t          op_e;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] sc_result;
    logic             sc_c;
    logic             sc_v;
    logic             goes_div;

    logic             div_load;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_last;
    logic [WIDTH-1:0] div_result;

    assign op_e = alu_op_t'(op);

    // Single-cycle datapath, evaluated on the live operands; it is only
    // consumed on the edge that accepts start.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        goes_div  = 1'b0;
        case (op_e)
            OP_ADD: begin
                sc_result = sum[WIDTH-1:0];
                sc_c      = sum[WIDTH];
                // Overflow: like-signed operands produce an opposite sign.
                sc_v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff[WIDTH-1:0];
                // Carry is the inverted borrow (set when a >= b unsigned).
                sc_c      = ~diff[WIDTH];
                sc_v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                sc_result = prod[WIDTH-1:0];
                sc_v      = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV, OP_MOD: begin
                if (b == '0) begin
                    sc_result = (op_e == OP_DIV) ? {WIDTH{1'b1}} : a;
                    sc_v      = 1'b1;
                end else begin
                    goes_div  = 1'b1;
                end
            end
            OP_MOV: begin
                sc_result = b;
            end
            default: begin
                // Illegal opcode: zero result, which yields Z-only flags.
                sc_result = '0;
            end
        endcase
    end

    assign div_load   = (state_q == IDLE) && start && goes_div;
    assign div_result = is_mod_q ? div_rem : div_quo;

    div_restoring #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend (a),
        .divisor  (b),
        .quotient (div_quo),
        .remainder(div_rem),
        .last     (div_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            is_mod_q <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (goes_div) begin
                            state_q  <= DIV_RUN;
                            is_mod_q <= (op_e == OP_MOD);
                        end else begin
                            result_q <= sc_result;
                            flags_q  <= pack_flags(sc_result[WIDTH-1], sc_result == '0,
                                                   sc_c, sc_v);
                            done_q   <= 1'b1;
                        end
                    end
                end
                DIV_RUN: begin
                    // start is deliberately not looked at here.
                    if (div_last) begin
                        result_q <= div_result;
                        flags_q  <= pack_flags(div_result[WIDTH-1], div_result == '0,
                                               1'b0, 1'b0);
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == DIV_RUN);
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu at WIDTH=32 and WIDTH=8.
// Directed vector table, hand-written multi-cycle sequences, and randomized
// operations compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, start8;
    logic [2:0]  op, op8;
    logic [31:0] a, b, result;
    logic [7:0]  a8, b8, result8;
    logic        busy, done, busy8, done8;
    logic [3:0]  flags, flags8;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .flags(flags8)
    );

    typedef struct {
        bit          w8;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit w8, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] r,
                           input logic [3:0] f, input int l);
        vec_t v;
        v.w8 = w8; v.op = o; v.a = x; v.b = y; v.res = r; v.flg = f; v.lat = l;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    // Returns {flags, result} with result zero-extended to 32 bits.
    function automatic logic [35:0] model(input int w, input logic [2:0] o,
                                          input logic [31:0] x, input logic [31:0] y);
        longint unsigned mask, xa, yb, r;
        longint          sx, sy, s, smax, smin;
        bit              n, z, c, v;
        mask = (64'd1 << w) - 1;
        xa   = {32'd0, x} & mask;
        yb   = {32'd0, y} & mask;
        sx   = ((xa >> (w - 1)) != 0) ? longint'(xa) - (longint'(1) << w) : longint'(xa);
        sy   = ((yb >> (w - 1)) != 0) ? longint'(yb) - (longint'(1) << w) : longint'(yb);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -smax - 1;
        c = 0; v = 0; r = 0;
        case (o)
            3'd0: begin r = xa + yb; c = (r > mask); s = sx + sy; v = (s > smax) || (s < smin); end
            3'd1: begin r = xa - yb; c = (xa >= yb); s = sx - sy; v = (s > smax) || (s < smin); end
            3'd2: begin r = xa * yb; v = ((r >> w) != 0); end
            3'd3: begin if (yb == 0) begin r = mask; v = 1; end else r = xa / yb; end
            3'd4: begin if (yb == 0) begin r = xa; v = 1; end else r = xa % yb; end
            3'd5: r = yb;
            default: r = 0;
        endcase
        r = r & mask;
        n = ((r >> (w - 1)) & 1) != 0;
        z = (r == 0);
        return {n, z, c, v, r[31:0]};
    endfunction

    // Issue one operation, scramble the operands after capture, and wait
    // (bounded) for done. lat counts edges from the start edge inclusive.
    task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] r,
                          output logic [3:0] f, output int lat, output int bcnt);
        logic d;
        if (w8) begin start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; end
        else    begin start  = 1'b1; op  = o; a  = x;      b  = y;      end
        tick;
        start = 1'b0; start8 = 1'b0;
        a = $urandom; b = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 1; bcnt = 0;
        d = w8 ? done8 : done;
        while (!d && lat < 100) begin
            if (w8 ? busy8 : busy) bcnt++;
            tick;
            lat++;
            d = w8 ? done8 : done;
        end
        check("done_seen", {63'd0, d}, 64'd1);
        r = w8 ? {24'd0, result8} : result;
        f = w8 ? flags8 : flags;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, x, y, mask;
        logic [3:0]  f;
        logic [35:0] exp;
        int          lat, bcnt, n, w;
        bit          seen, w8;
        logic [2:0]  o;

        rst = 1'b1; start = 1'b0; start8 = 1'b0;
        op = 3'd0; a = '0; b = '0; op8 = 3'd0; a8 = '0; b8 = '0;

        // ---------------- reset ----------------
        tick; tick;
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_flags",  {60'd0, flags},  64'd0);
        check("rst_done",   {63'd0, done},   64'd0);
        check("rst_busy",   {63'd0, busy},   64'd0);
        check("rst_result8", {56'd0, result8}, 64'd0);
        check("rst_busy8",  {63'd0, busy8},  64'd0);

        start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
        start8 = 1'b1; op8 = 3'd3; a8 = 8'd9; b8 = 8'd3;
        tick;
        check("rst_start_done",   {63'd0, done},   64'd0);
        check("rst_start_result", {32'd0, result}, 64'd0);
        check("rst_start_busy8",  {63'd0, busy8},  64'd0);
        start = 1'b0; start8 = 1'b0; rst = 1'b0;
        tick;

        // ---------------- directed vector table ----------------
        add_vec(0, 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1);
        add_vec(0, 3'd1, 32'd5,        32'd5,        32'd0,        4'b0110, 1);
        add_vec(0, 3'd2, 32'h00010000, 32'h00010000, 32'd0,        4'b0101, 1);
        add_vec(0, 3'd2, 32'd7,        32'd6,        32'd42,       4'b0000, 1);
        add_vec(0, 3'd5, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 1);
        add_vec(0, 3'd3, 32'd100,      32'd7,        32'd14,       4'b0000, 33);
        add_vec(0, 3'd4, 32'd100,      32'd7,        32'd2,        4'b0000, 33);
        add_vec(0, 3'd3, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b1001, 1);
        add_vec(0, 3'd4, 32'd9,        32'd0,        32'd9,        4'b0001, 1);
        add_vec(0, 3'd6, 32'd5,        32'd3,        32'd0,        4'b0100, 1);
        add_vec(0, 3'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b1000, 1);
        add_vec(0, 3'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0110, 1);
        add_vec(0, 3'd1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011, 1);
        add_vec(0, 3'd3, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b1000, 33);
        add_vec(1, 3'd3, 32'hFF,       32'd1,        32'hFF,       4'b1000, 9);
        add_vec(1, 3'd4, 32'hFF,       32'h10,       32'h0F,       4'b0000, 9);
        add_vec(1, 3'd0, 32'h7F,       32'h01,       32'h80,       4'b1001, 1);
        add_vec(1, 3'd2, 32'h10,       32'h10,       32'h00,       4'b0101, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, bcnt);
            check($sformatf("vec%0d_result", i),  {32'd0, r},   {32'd0, vecs[i].res});
            check($sformatf("vec%0d_flags", i),   {60'd0, f},   {60'd0, vecs[i].flg});
            check($sformatf("vec%0d_latency", i), 64'(lat),     64'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i),    64'(bcnt),    64'(vecs[i].lat - 1));
            tick;
            check($sformatf("vec%0d_done_width", i),
                  {63'd0, vecs[i].w8 ? done8 : done}, 64'd0);
            check($sformatf("vec%0d_held", i),
                  {32'd0, vecs[i].w8 ? {24'd0, result8} : result}, {32'd0, vecs[i].res});
        end

        // ---------------- back-to-back single-cycle ops ----------------
        start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd2;
        tick;
        check("b2b_done1",   {63'd0, done},   64'd1);
        check("b2b_result1", {32'd0, result}, 64'd3);
        op = 3'd5; b = 32'd5;
        tick;
        check("b2b_done2",   {63'd0, done},   64'd1);
        check("b2b_result2", {32'd0, result}, 64'd5);
        start = 1'b0;
        tick;
        check("b2b_done_off", {63'd0, done},  64'd0);
        check("b2b_held",    {32'd0, result}, 64'd5);

        // ---------------- start toggled during a divide ----------------
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0;
        check("tog_busy", {63'd0, busy}, 64'd1);
        n = 1; seen = 0;
        for (int i = 0; i < 30; i++) begin
            start = i[0]; op = 3'd0; a = $urandom; b = $urandom;
            tick;
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        while (!done && n < 80) begin
            tick;
            n++;
        end
        check("tog_no_early_done", {63'd0, seen}, 64'd0);
        check("tog_latency", 64'(n), 64'd33);
        check("tog_result", {32'd0, result}, 64'd14);
        check("tog_flags",  {60'd0, flags},  64'd0);
        tick;
        check("tog_done_off", {63'd0, done}, 64'd0);
        check("tog_busy_off", {63'd0, busy}, 64'd0);
        check("tog_held", {32'd0, result}, 64'd14);

        // ---------------- reset aborts a running divide ----------------
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0;
        repeat (9) tick;
        rst = 1'b1;
        tick;
        check("abort_busy",   {63'd0, busy},   64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        check("abort_done",   {63'd0, done},   64'd0);
        check("abort_flags",  {60'd0, flags},  64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            tick;
            if (done || busy) seen = 1;
        end
        check("abort_no_done", {63'd0, seen}, 64'd0);
        run_op(0, 3'd0, 32'd2, 32'd3, r, f, lat, bcnt);
        check("post_abort_result",  {32'd0, r}, 64'd5);
        check("post_abort_flags",   {60'd0, f}, 64'd0);
        check("post_abort_latency", 64'(lat),   64'd1);

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 150; i++) begin
            w8 = (i % 3 == 0);
            w  = w8 ? 8 : 32;
            mask = w8 ? 32'hFF : 32'hFFFFFFFF;
            o  = 3'($urandom_range(0, 7));
            x  = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) x = $urandom_range(0, 255);
            exp = model(w, o, x, y);
            run_op(w8, o, x, y, r, f, lat, bcnt);
            check($sformatf("rnd%0d_op%0d_%0h_%0h", i, o, x, y),
                  {28'd0, f, r}, {28'd0, exp});
            check($sformatf("rnd%0d_latency", i), 64'(lat),
                  ((o == 3'd3 || o == 3'd4) && (y & mask) != 0) ? 64'(w + 1) : 64'd1);
            tick;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Sequential, parametrised successor to the CPU's combinational ALU. A single operation, selected by opcode, is accepted under a start/busy/done handshake, and its result and NZCV flags are registered. ADD, SUB, MUL and MOV complete in one cycle. DIV and MOD run on an iterative restoring divider over WIDTH cycles. The block sits in the execute stage and stalls the pipeline through `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (≥4).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 MOV, 6–7 illegal.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B (MOV source).
- `busy`  out  1  divider iterating; new `start` ignored.
- `done`  out  1  one-cycle pulse; `result`/`flags` just updated.
- `result`  out  WIDTH  registered result, held until next completion.
- `flags`  out  4  registered {N,Z,C,V} (bit3..bit0).

## Operation
- FSM states: IDLE, DIV_RUN.
- In IDLE, `start`=1 captures `op`, `a` and `b`.
- ADD, SUB, MUL, MOV and illegal ops complete from IDLE directly.
- DIV/MOD with `b`≠0 move to DIV_RUN. DIV/MOD with `b`=0 completes directly.
- Arithmetic (two's complement, results truncated to WIDTH):
  - ADD: a+b. C = carry out. V = signed overflow.
  - SUB: a−b. C = 1 when no borrow (a ≥ b unsigned). V = signed overflow.
  - MUL: low WIDTH bits of the unsigned product. C=0. V=1 if the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - DIV/MOD: unsigned quotient/remainder. C=0, V=0.
  - Divide by zero: DIV returns all-ones, MOD returns `a`, V=1.
  - MOV: result = b. C=V=0.
  - Illegal op: result 0, flags 4'b0100 (Z only).
- N = result[WIDTH-1]. Z = (result == 0).
- Divider: restoring, one quotient bit per cycle, MSB first. Registers: remainder (WIDTH+1 bits), quotient, divisor, and a bit counter of $clog2(WIDTH) bits.
- `start` while `busy`=1 is ignored. It is neither queued nor allowed to corrupt the running operation.
- Operand inputs may change freely after capture.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `flags`=0, FSM = IDLE, divider registers = 0.
- `rst` mid-operation aborts DIV_RUN at that edge. No `done` is produced. `rst` has priority over `start` at the same edge.
- Single-cycle ops: with `start` high at edge k, `result`, `flags` and `done`=1 are visible after edge k. Latency is 1. `busy` stays 0.
- Back-to-back single-cycle starts on consecutive edges each produce their own `done` pulse.
- DIV/MOD (b≠0), with `start` at edge k:
  - `busy`=1 after edge k.
  - Iterations occur at edges k+1 … k+WIDTH.
  - At edge k+WIDTH the final bit is resolved and `result`/`flags` are written. `done`=1 and `busy`=0 take effect at the same edge.
  - Latency is WIDTH+1 edges from the start edge; for WIDTH=32 that is `done` after edge k+32… more precisely, `done` is visible in the cycle following edge k+WIDTH.
- A new `start` is accepted at the same edge where `done` is asserted, because `busy` was 1 before that edge? No: `start` is accepted at the first edge where `busy` is sampled 0, which is edge k+WIDTH+1.
- `done` is exactly one cycle wide. It deasserts after the next edge unless another completion occurs at that edge.

## Structure
- Package `alu_pkg` holds:
  - `typedef enum logic [2:0] alu_op_t` (OP_ADD … OP_MOV).
  - Flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - FSM state enum `alu_state_t`.
- One sub-module, `div_restoring #(WIDTH)`:
  - Ports: `clk`, `rst`, `load`, `dividend`, `divisor`.
  - Outputs: `quotient`, `remainder`, `last` (high during the final iteration).
- The top level holds the FSM, the single-cycle datapath, flag generation and the output registers.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs 0. Drive `start` with `rst` high → no `done`.
- ADD 0x7FFFFFFF+1 → result 0x80000000, flags N=1, V=1, C=0, Z=0, `done` one cycle after start. SUB 5−5 → result 0, flags Z=1, C=1.
- MUL 0x00010000×0x00010000 → result 0, flags Z=1, V=1. MUL 7×6 → result 42, V=0. MOV b=0xFFFFFFFF → N=1.
- DIV 100/7 → `busy` for 32 cycles, then result 14. MOD 100/7 → result 2. Toggle `start` mid-run → ignored, result unchanged.
- Divide by zero: DIV 9/0 → result 0xFFFFFFFF, V=1, latency 1. MOD 9/0 → result 9, V=1.
- Assert `rst` during cycle 10 of a DIV → `busy`=0 and `result`=0 next cycle, no `done`. An ADD after reset completes normally. Repeat DIV 0xFFFFFFFF/1 with WIDTH=8 (0xFF/1 → 0xFF) to check parametrisation.
